// File: rtl/phys_reg_free_list.sv
// Free list of physical register tags for rename: multi-lane
// allocate/free, with head checkpoints for one-cycle mispredict
// recovery. Checkpoints exist only with
// PHYS_REG_FREE_LIST_CHECKPOINT_EN defined.
// Ports: CLK, RST (sync, active-high); deq_req/deq_ready/deq_tag
// allocate; enq_valid/enq_tag free; save_*/restore_* checkpoint;
// count/empty/full status.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int DEQ_WIDTH = 2,
    parameter int ENQ_WIDTH = 2,
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter int PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS),
    parameter int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS),
    parameter int COUNT_WIDTH =
        $clog2(NUM_PHYS_REGS - NUM_ARCH_REGS) + 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic [DEQ_WIDTH-1:0] deq_req,
    output logic deq_ready,
    output logic [DEQ_WIDTH-1:0][PHYS_REG_WIDTH-1:0] deq_tag,
    input  logic [ENQ_WIDTH-1:0] enq_valid,
    input  logic [ENQ_WIDTH-1:0][PHYS_REG_WIDTH-1:0] enq_tag,
    input  logic save_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
    input  logic restore_valid,
    input  logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
    output logic [COUNT_WIDTH-1:0] count,
    output logic empty,
    output logic full
);

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_W = COUNT_WIDTH;
    localparam int IDX_W = COUNT_WIDTH - 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PHYS_REG_WIDTH-1:0] mem [DEPTH];

    // MSB of each pointer is the wrap bit
    ptr_t head;
    ptr_t tail;
    ptr_t ndeq;
    ptr_t nenq;
    ptr_t head_adv;
    ptr_t head_next;
    ptr_t restore_head;
    logic restore_en;
    ptr_t deq_ptr [DEQ_WIDTH];
    ptr_t enq_ptr [ENQ_WIDTH];

    assign count = tail - head;
    assign empty = (count == '0);
    assign full  = (count == ptr_t'(DEPTH));

    always_comb begin
        ndeq = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            ndeq = ndeq + ptr_t'(deq_req[i]);
        end
    end

    // Valid enqueue lanes are packed densely starting at tail
    always_comb begin
        nenq = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            enq_ptr[i] = tail + nenq;
            nenq = nenq + ptr_t'(enq_valid[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_ptr[i] = head + ptr_t'(i);
            deq_tag[i] = mem[deq_ptr[i][IDX_W-1:0]];
        end
    end

    // A restore squashes this cycle's allocation
    assign deq_ready = (count >= ndeq) && !restore_en;
    assign head_adv  = deq_ready ? head + ndeq : head;
    assign head_next = restore_en ? restore_head : head_adv;

`ifdef PHYS_REG_FREE_LIST_CHECKPOINT_EN
    ptr_t ckpt [CHECKPOINT_COLUMNS];

    assign restore_en   = restore_valid;
    assign restore_head = ckpt[restore_column];

    // Saved head includes the branch's own allocation
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                ckpt[c] <= '0;
            end
        end else if (save_valid && !restore_valid) begin
            ckpt[save_column] <= head_adv;
        end
    end
`else
    logic unused_ckpt;

    assign restore_en   = 1'b0;
    assign restore_head = '0;
    assign unused_ckpt  = ^{save_valid, save_column,
                            restore_valid, restore_column};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            head <= '0;
            tail <= ptr_t'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
            end
        end else begin
            head <= head_next;
            tail <= tail + nenq;
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (enq_valid[i]) begin
                    mem[enq_ptr[i][IDX_W-1:0]] <= enq_tag[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list (default 64/32/2/2/4).
// Checkpoint cases follow PHYS_REG_FREE_LIST_CHECKPOINT_EN.
module tb_phys_reg_free_list;

    logic CLK = 1'b0;
    logic RST;
    logic [1:0] deq_req;
    logic deq_ready;
    logic [1:0][5:0] deq_tag;
    logic [1:0] enq_valid;
    logic [1:0][5:0] enq_tag;
    logic save_valid;
    logic [1:0] save_column;
    logic restore_valid;
    logic [1:0] restore_column;
    logic [5:0] count;
    logic empty;
    logic full;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    phys_reg_free_list dut (
        .CLK(CLK),
        .RST(RST),
        .deq_req(deq_req),
        .deq_ready(deq_ready),
        .deq_tag(deq_tag),
        .enq_valid(enq_valid),
        .enq_tag(enq_tag),
        .save_valid(save_valid),
        .save_column(save_column),
        .restore_valid(restore_valid),
        .restore_column(restore_column),
        .count(count),
        .empty(empty),
        .full(full)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        deq_req = '0;
        enq_valid = '0;
        enq_tag = '0;
        save_valid = 1'b0;
        save_column = '0;
        restore_valid = 1'b0;
        restore_column = '0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        step();
        do_reset();
        #1;
        check("rst_count", count, 32);
        check("rst_full", full, 1);
        check("rst_empty", empty, 0);
        check("rst_ready", deq_ready, 1);
        check("rst_tag0", deq_tag[0], 32);
        check("rst_tag1", deq_tag[1], 33);

        // drain in pairs
        for (int k = 0; k < 16; k++) begin
            deq_req = 2'b11;
            #1;
            check("drain_ready", deq_ready, 1);
            check("drain_tag0", deq_tag[0], 32 + 2 * k);
            check("drain_tag1", deq_tag[1], 33 + 2 * k);
            step();
        end
        deq_req = 2'b00;
        #1;
        check("drained_count", count, 0);
        check("drained_empty", empty, 1);
        check("drained_full", full, 0);
        deq_req = 2'b11;
        #1;
        check("empty_ready2", deq_ready, 0);
        step();
        deq_req = 2'b01;
        #1;
        check("empty_ready1", deq_ready, 0);
        check("empty_hold", count, 0);

        // refill 0..31 across the wrap
        deq_req = 2'b00;
        for (int k = 0; k < 16; k++) begin
            enq_valid = 2'b11;
            enq_tag[0] = 6'(2 * k);
            enq_tag[1] = 6'(2 * k + 1);
            step();
        end
        idle();
        #1;
        check("refill_count", count, 32);
        check("refill_full", full, 1);
        check("wrap_tag0", deq_tag[0], 0);
        check("wrap_tag1", deq_tag[1], 1);
        deq_req = 2'b11;
        step();
        idle();
        #1;
        check("wrap2_tag0", deq_tag[0], 2);
        check("wrap2_tag1", deq_tag[1], 3);
        check("wrap2_count", count, 30);

        // reset while allocating and freeing
        deq_req = 2'b11;
        enq_valid = 2'b01;
        enq_tag[0] = 6'd9;
        RST = 1'b1;
        step();
        RST = 1'b0;
        idle();
        #1;
        check("midrst_count", count, 32);
        check("midrst_tag0", deq_tag[0], 32);

        // single-lane alloc, then free on lane 1 only
        deq_req = 2'b01;
        #1;
        check("one_ready", deq_ready, 1);
        check("one_tag0", deq_tag[0], 32);
        step();
        #1;
        check("one_count", count, 31);
        deq_req = 2'b01;
        enq_valid = 2'b10;
        enq_tag[0] = 6'd9;
        enq_tag[1] = 6'd5;
        #1;
        check("lane1_tag0", deq_tag[0], 33);
        step();
        idle();
        #1;
        check("lane1_count", count, 31);
        for (int k = 0; k < 15; k++) begin
            deq_req = 2'b11;
            #1;
            check("d2_tag0", deq_tag[0], 34 + 2 * k);
            step();
        end
        idle();
        #1;
        check("low_count", count, 1);
        check("lane1_written", deq_tag[0], 5);

        // count=1 vs 2 requests, no bypass
        deq_req = 2'b11;
        #1;
        check("short_ready", deq_ready, 0);
        step();
        #1;
        check("short_hold", count, 1);
        check("short_tag0", deq_tag[0], 5);
        enq_valid = 2'b01;
        enq_tag[0] = 6'd7;
        #1;
        check("nobypass_ready", deq_ready, 0);
        step();
        enq_valid = 2'b00;
        #1;
        check("after_enq_count", count, 2);
        check("after_enq_ready", deq_ready, 1);
        check("after_enq_tag0", deq_tag[0], 5);
        check("after_enq_tag1", deq_tag[1], 7);
        step();
        idle();
        #1;
        check("final_empty", empty, 1);

        // checkpoints
        do_reset();
`ifdef PHYS_REG_FREE_LIST_CHECKPOINT_EN
        save_valid = 1'b1;
        save_column = 2'd2;
        deq_req = 2'b11;
        #1;
        check("save_tag0", deq_tag[0], 32);
        step();
        save_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            deq_req = 2'b11;
            step();
        end
        idle();
        #1;
        check("spec_count", count, 22);
        check("spec_tag0", deq_tag[0], 42);
        restore_valid = 1'b1;
        restore_column = 2'd2;
        deq_req = 2'b11;
        enq_valid = 2'b11;
        enq_tag[0] = 6'd3;
        enq_tag[1] = 6'd4;
        #1;
        check("restore_ready", deq_ready, 0);
        step();
        idle();
        #1;
        check("restore_tag0", deq_tag[0], 34);
        check("restore_count", count, 32);
        check("restore_full", full, 1);
`else
        save_valid = 1'b1;
        save_column = 2'd2;
        restore_valid = 1'b1;
        restore_column = 2'd0;
        deq_req = 2'b11;
        #1;
        check("nockpt_ready", deq_ready, 1);
        check("nockpt_tag0", deq_tag[0], 32);
        step();
        idle();
        #1;
        check("nockpt_count", count, 30);
        check("nockpt_tag0b", deq_tag[0], 34);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
